// File: rtl/router_ctrl_fsm.sv
// Router control FSM: sequences header decode, payload load, FIFO-full stall and parity check.
// Optional feature: define ROUTER_CTRL_SOFT_RESET_EN to let the selected port's soft_reset abort a packet.
module router_ctrl_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);

  localparam logic [2:0] DECODE_ADDRESS     = 3'd0;
  localparam logic [2:0] LOAD_FIRST_DATA    = 3'd1;
  localparam logic [2:0] LOAD_DATA          = 3'd2;
  localparam logic [2:0] FIFO_FULL_STATE    = 3'd3;
  localparam logic [2:0] LOAD_AFTER_FULL    = 3'd4;
  localparam logic [2:0] LOAD_PARITY        = 3'd5;
  localparam logic [2:0] CHECK_PARITY_ERROR = 3'd6;
  localparam logic [2:0] WAIT_TILL_EMPTY    = 3'd7;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [1:0] r_addr;
  logic [3:0] w_empty_ext;
  logic [3:0] w_soft_ext;

  // Padding to four entries lets address 3 index safely; it is never used to route.
  assign w_empty_ext = {1'b0, fifo_empty};
  assign w_soft_ext  = {1'b0, soft_reset};

  always_comb begin
    w_next = r_state;
    case (r_state)
      DECODE_ADDRESS: begin
        if (pkt_valid && (data_in != 2'd3)) begin
          w_next = w_empty_ext[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (w_empty_ext[r_addr]) w_next = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: w_next = LOAD_DATA;
      LOAD_DATA: begin
        if (fifo_full)       w_next = FIFO_FULL_STATE;
        else if (!pkt_valid) w_next = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full) w_next = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)        w_next = DECODE_ADDRESS;
        else if (low_pkt_valid) w_next = LOAD_PARITY;
        else                    w_next = LOAD_DATA;
      end
      LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            w_next = DECODE_ADDRESS;
    endcase
`ifdef ROUTER_CTRL_SOFT_RESET_EN
    // Only the port this packet is routed to may abort it.
    if ((r_state != DECODE_ADDRESS) && w_soft_ext[r_addr]) w_next = DECODE_ADDRESS;
`endif
  end

`ifndef ROUTER_CTRL_SOFT_RESET_EN
  logic w_unused_soft_reset;
  assign w_unused_soft_reset = ^w_soft_ext;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= DECODE_ADDRESS;
      r_addr  <= 2'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == DECODE_ADDRESS) && (w_next != DECODE_ADDRESS)) r_addr <= data_in;
    end
  end

  assign detect_add    = (r_state == DECODE_ADDRESS);
  assign lfd_state     = (r_state == LOAD_FIRST_DATA);
  assign ld_state      = (r_state == LOAD_DATA);
  assign laf_state     = (r_state == LOAD_AFTER_FULL);
  assign full_state    = (r_state == FIFO_FULL_STATE);
  assign rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
  assign write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                         (r_state == LOAD_AFTER_FULL);
  assign busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Self-checking bench for router_ctrl_fsm: expected output vectors are queued as stimulus is
// driven and compared after each clock edge; soft-reset checks follow ROUTER_CTRL_SOFT_RESET_EN.
module tb_router_ctrl_fsm;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, write_enb_reg, busy;

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0] expQueue[$];
  string      tagQueue[$];

  // Output vector bit order: detect_add, lfd, ld, laf, full, rst_int, write_enb, busy
  localparam logic [7:0] E_DA  = 8'b1000_0000;
  localparam logic [7:0] E_LFD = 8'b0100_0001;
  localparam logic [7:0] E_LD  = 8'b0010_0010;
  localparam logic [7:0] E_LAF = 8'b0001_0011;
  localparam logic [7:0] E_FFS = 8'b0000_1001;
  localparam logic [7:0] E_CPE = 8'b0000_0101;
  localparam logic [7:0] E_LP  = 8'b0000_0011;
  localparam logic [7:0] E_WTE = 8'b0000_0001;

  logic [7:0] obsVec;
  assign obsVec = {detect_add, lfd_state, ld_state, laf_state,
                   full_state, rst_int_reg, write_enb_reg, busy};

  router_ctrl_fsm dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, queue the state expected after the next
  // rising edge, then compare shortly after that edge.
  task automatic applyStimulus(input logic pv, input logic [1:0] din, input logic [2:0] fe,
                               input logic ff, input logic pd, input logic lpv,
                               input logic [2:0] sr, input logic [7:0] exp, input string tag);
    @(negedge clock);
    pkt_valid = pv; data_in = din; fifo_empty = fe; fifo_full = ff;
    parity_done = pd; low_pkt_valid = lpv; soft_reset = sr;
    expQueue.push_back(exp);
    tagQueue.push_back(tag);
    @(posedge clock);
    #1;
    if (expQueue.size() == 0) begin
      failCount++;
      $display("[TB] FAIL %s: scoreboard empty got %b expected entry", tag, obsVec);
    end else begin
      checkOutput(tagQueue.pop_front(), obsVec, expQueue.pop_front());
    end
  endtask

  initial begin
    reset = 1'b1; pkt_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
    #3;
    checkOutput("reset_state", obsVec, E_DA);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Normal packet to port 2 with four payload bytes
    applyStimulus(1, 2'd2, 3'b111, 0, 0, 0, 3'b000, E_LFD, "p2_lfd");
    applyStimulus(1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD,  "p2_ld1");
    for (int i = 2; i <= 4; i++)
      applyStimulus(1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD, $sformatf("p2_ld%0d", i));
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LP,  "p2_lp");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_CPE, "p2_cpe");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_DA,  "p2_da");

    // Port 1 busy: wait three cycles in WTE; data_in changes must not disturb the latched address
    applyStimulus(1, 2'd1, 3'b101, 0, 0, 0, 3'b000, E_WTE, "p1_wte1");
    applyStimulus(1, 2'd0, 3'b101, 0, 0, 0, 3'b000, E_WTE, "p1_wte2");
    applyStimulus(1, 2'd2, 3'b101, 0, 0, 0, 3'b000, E_WTE, "p1_wte3");
    applyStimulus(1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LFD, "p1_lfd");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD,  "p1_ld");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LP,  "p1_lp");
    applyStimulus(0, 2'd0, 3'b111, 1, 0, 0, 3'b000, E_CPE, "p1_cpe");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_DA,  "p1_da");

    // FIFO-full stall on port 0, then the LAF exits and CPE-to-FFS path
    applyStimulus(1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LFD, "p0_lfd");
    applyStimulus(1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD,  "p0_ld1");
    applyStimulus(1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD,  "p0_ld2");
    applyStimulus(1, 2'd0, 3'b111, 1, 0, 0, 3'b000, E_FFS, "p0_ffs1");
    applyStimulus(1, 2'd0, 3'b111, 1, 0, 0, 3'b000, E_FFS, "p0_ffs2");
    applyStimulus(1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LAF, "p0_laf1");
    applyStimulus(1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD,  "p0_laf_to_ld");
    applyStimulus(0, 2'd0, 3'b111, 1, 0, 0, 3'b000, E_FFS, "p0_full_priority");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LAF, "p0_laf2");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 1, 3'b000, E_LP,  "p0_laf_to_lp");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_CPE, "p0_cpe");
    applyStimulus(0, 2'd0, 3'b111, 1, 0, 0, 3'b000, E_FFS, "p0_cpe_to_ffs");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LAF, "p0_laf3");
    applyStimulus(0, 2'd0, 3'b111, 0, 1, 1, 3'b000, E_DA,  "p0_laf_to_da");

    // Invalid address 3 never leaves DA
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 2'd3, 3'b111, 0, 0, 0, 3'b000, E_DA, $sformatf("addr3_da%0d", i));

    // Asynchronous reset in the middle of a packet
    applyStimulus(1, 2'd2, 3'b111, 0, 0, 0, 3'b000, E_LFD, "rst_lfd");
    applyStimulus(1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD,  "rst_ld");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", obsVec, E_DA);
    pkt_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_DA,  "post_rst_idle");
    applyStimulus(1, 2'd1, 3'b111, 0, 0, 0, 3'b000, E_LFD, "post_rst_lfd");
    applyStimulus(1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD,  "post_rst_ld");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LP,  "post_rst_lp");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_CPE, "post_rst_cpe");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_DA,  "post_rst_da");

    // Soft reset on a port-2 packet stalled in FFS
    applyStimulus(1, 2'd2, 3'b111, 0, 0, 0, 3'b000, E_LFD, "sr_lfd");
    applyStimulus(1, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_LD,  "sr_ld");
    applyStimulus(1, 2'd0, 3'b111, 1, 0, 0, 3'b000, E_FFS, "sr_ffs");
    applyStimulus(1, 2'd0, 3'b111, 1, 0, 0, 3'b001, E_FFS, "sr_other_port");
`ifdef ROUTER_CTRL_SOFT_RESET_EN
    applyStimulus(1, 2'd0, 3'b111, 1, 0, 0, 3'b100, E_DA,  "sr_own_port");
`else
    applyStimulus(1, 2'd0, 3'b111, 1, 0, 0, 3'b100, E_FFS, "sr_ignored");
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b100, E_LAF, "sr_laf");
    applyStimulus(0, 2'd0, 3'b111, 0, 1, 0, 3'b100, E_DA,  "sr_da");
`endif
    applyStimulus(0, 2'd0, 3'b111, 0, 0, 0, 3'b000, E_DA,  "final_idle");

    if (expQueue.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", expQueue.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
